// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined floating-point multiplier among N_REQ requesters.
// Operand pairs are granted one per cycle, either round-robin (default) or by fixed priority.
// The granted pair goes to an issue register that drives the multiplier's stream inputs.
// The winner's index is pushed into a tag FIFO. Results are steered back in issue order.
//
// Optional feature macro: FP_ARB_FIXED_PRIO_EN (lowest index wins, no round-robin state).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester operand handshake (ready is one-hot)
//   req_a/req_b                     packed operands, requester i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   res_valid/res_ready/res_data    one-hot result handshake, shared result data
//   m_a_*/m_b_*                     multiplier operand streams
//   m_res_*                         multiplier result stream
//   err_orphan                      sticky flag: a result arrived with no outstanding tag
module fp_mult_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]            res_valid,
    input  logic [N_REQ-1:0]            res_ready,
    output logic [DATA_WIDTH-1:0]       res_data,
    output logic                        m_a_tvalid,
    output logic                        m_b_tvalid,
    output logic [DATA_WIDTH-1:0]       m_a_tdata,
    output logic [DATA_WIDTH-1:0]       m_b_tdata,
    input  logic                        m_a_tready,
    input  logic                        m_b_tready,
    input  logic                        m_res_tvalid,
    input  logic [DATA_WIDTH-1:0]       m_res_tdata,
    output logic                        m_res_tready,
    output logic                        err_orphan
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  iss_valid_q;
    logic [DATA_WIDTH-1:0] iss_a_q, iss_b_q;
    logic [IDX_W-1:0]      tag_mem_q [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      tag_cnt_q;
    logic                  err_q;
`ifndef FP_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]      last_q;
`endif

    logic                  xfer, iss_free, fifo_empty, fifo_full;
    logic                  gnt_found, grant, pop, head_ready;
    logic [IDX_W-1:0]      gnt_idx, head;
    logic [DATA_WIDTH-1:0] gnt_a, gnt_b;

    assign xfer       = iss_valid_q & m_a_tready & m_b_tready;
    assign iss_free   = ~iss_valid_q | xfer;
    assign fifo_empty = (tag_cnt_q == '0);
    // A pop in the same cycle does not free a slot for a grant when full.
    assign fifo_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
    assign head       = tag_mem_q[rd_ptr_q];
    assign grant      = gnt_found & iss_free & ~fifo_full;

    // Winner search; round-robin starts one past the last winner and wraps.
    always_comb begin
        int cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_q) + 1 + k) % N_REQ;
`endif
            if (!gnt_found && req_valid[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Per-requester decode: grant, operand mux and result steering.
    always_comb begin
        req_ready  = '0;
        res_valid  = '0;
        gnt_a      = '0;
        gnt_b      = '0;
        head_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                req_ready[i] = grant;
                gnt_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (head == IDX_W'(i)) begin
                res_valid[i] = m_res_tvalid & ~fifo_empty;
                head_ready   = res_ready[i];
            end
        end
    end

    // With no outstanding tag the result is an orphan: accept it so the multiplier drains.
    assign m_res_tready = fifo_empty ? m_res_tvalid : head_ready;
    assign pop          = m_res_tvalid & m_res_tready & ~fifo_empty;
    assign res_data     = m_res_tdata;
    assign m_a_tvalid   = iss_valid_q;
    assign m_b_tvalid   = iss_valid_q;
    assign m_a_tdata    = iss_a_q;
    assign m_b_tdata    = iss_b_q;
    assign err_orphan   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_cnt_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
`ifndef FP_ARB_FIXED_PRIO_EN
            last_q      <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            if (grant) begin
                iss_valid_q         <= 1'b1;
                iss_a_q             <= gnt_a;
                iss_b_q             <= gnt_b;
                tag_mem_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
`ifndef FP_ARB_FIXED_PRIO_EN
                last_q              <= gnt_idx;
`endif
            end else if (xfer) begin
                iss_valid_q <= 1'b0;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (grant && !pop) begin
                tag_cnt_q <= tag_cnt_q + CNT_W'(1);
            end else if (!grant && pop) begin
                tag_cnt_q <= tag_cnt_q - CNT_W'(1);
            end
            if (m_res_tvalid && fifo_empty) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter with a stub multiplier model (exact when one operand is 1.0).
module tb_fp_mult_arbiter;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, res_valid, res_ready;
    logic [DW*N-1:0] req_a, req_b;
    logic [DW-1:0]   res_data, m_a_tdata, m_b_tdata, m_res_tdata;
    logic m_a_tvalid, m_b_tvalid, m_a_tready, m_b_tready;
    logic m_res_tvalid, m_res_tready, err_orphan;

    fp_mult_arbiter #(.DATA_WIDTH(DW), .N_REQ(N), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .m_a_tvalid(m_a_tvalid), .m_b_tvalid(m_b_tvalid),
        .m_a_tdata(m_a_tdata), .m_b_tdata(m_b_tdata),
        .m_a_tready(m_a_tready), .m_b_tready(m_b_tready),
        .m_res_tvalid(m_res_tvalid), .m_res_tdata(m_res_tdata), .m_res_tready(m_res_tready),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] d;
    } mres_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 6;
    int out_cnt = 0;
    int max_out = 0;
    logic [N-1:0] res_rdy_cfg = '1;
    logic tready_cfg = 1'b1;
    logic orphan_inj = 1'b0;

    logic [15:0] pend_q [N][$];
    logic [15:0] exp_q [N][$];
    mres_t       mq [$];
    int grant_log [$];
    int grant_cyc [$];
    int iss_cyc [$];
    int obs_order [$];
    int obs_cyc [$];
    logic [N-1:0] obs_vec [$];

    logic [N-1:0] gfire = '0;
    logic mfire = 1'b0, rfire_model = 1'b0, rpop = 1'b0;
    logic [15:0] ma = '0, mb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] fmul_stub(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00) return b;
        if (b == 16'h3C00) return a;
        return a ^ b;
    endfunction

    // Operand A is always 1.0, so the expected product is operand B.
    task automatic send(input int i, input logic [15:0] b);
        pend_q[i].push_back(b);
        exp_q[i].push_back(b);
    endtask

    function automatic bit idle();
        for (int i = 0; i < N; i++)
            if (pend_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return (mq.size() == 0) && (out_cnt == 0);
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!idle() && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drained"}, 32'(n < 2000), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_logs();
        grant_log.delete(); grant_cyc.delete(); iss_cyc.delete();
        obs_order.delete(); obs_cyc.delete(); obs_vec.delete();
        max_out = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst_n = 1'b0;
        mq.delete();
        out_cnt = 0;
        gfire = '0; mfire = 1'b0; rfire_model = 1'b0; rpop = 1'b0;
        clear_logs();
        @(negedge clk); #3;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_m_tvalid", 32'({m_a_tvalid, m_b_tvalid}), 0);
        chk("rst_m_tdata", 32'({m_a_tdata, m_b_tdata}), 0);
        chk("rst_m_res_tready", 32'(m_res_tready), 0);
        chk("rst_err_orphan", 32'(err_orphan), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requester drivers and multiplier model, all driven at the falling edge.
    initial begin
        req_valid = '0; req_a = '0; req_b = '0; res_ready = '1;
        m_a_tready = 1'b1; m_b_tready = 1'b1; m_res_tvalid = 1'b0; m_res_tdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++)
                if (gfire[i] && pend_q[i].size() != 0) void'(pend_q[i].pop_front());
            if (gfire != '0) out_cnt++;
            if (rpop) out_cnt--;
            if (mfire) mq.push_back('{t: cyc - 1 + lat, d: fmul_stub(ma, mb)});
            if (rfire_model && mq.size() != 0) void'(mq.pop_front());
            if (out_cnt > max_out) max_out = out_cnt;

            for (int i = 0; i < N; i++) begin
                req_valid[i] = (pend_q[i].size() != 0);
                req_a[i*DW +: DW] = req_valid[i] ? 16'h3C00 : 16'h0000;
                req_b[i*DW +: DW] = req_valid[i] ? pend_q[i][0] : 16'h0000;
            end
            m_a_tready = tready_cfg;
            m_b_tready = tready_cfg;
            res_ready = res_rdy_cfg;
            if (orphan_inj) begin
                m_res_tvalid = 1'b1; m_res_tdata = 16'h1234;
            end else if (mq.size() != 0 && mq[0].t <= cyc) begin
                m_res_tvalid = 1'b1; m_res_tdata = mq[0].d;
            end else begin
                m_res_tvalid = 1'b0; m_res_tdata = '0;
            end
            #1;
            gfire = req_valid & req_ready;
            mfire = m_a_tvalid & m_a_tready & m_b_tready;
            ma = m_a_tdata;
            mb = m_b_tdata;
            rfire_model = m_res_tvalid & m_res_tready & ~orphan_inj;
            rpop = |(res_valid & res_ready);
            if (req_ready != '0) begin
                chk("req_ready_onehot", 32'($countones(req_ready)), 1);
                for (int i = 0; i < N; i++)
                    if (gfire[i]) begin grant_log.push_back(i); grant_cyc.push_back(cyc); end
            end
            if (out_cnt == TD) chk("full_no_grant", 32'(req_ready), 0);
            if (mfire) iss_cyc.push_back(cyc);
        end
    end

    // Monitor: pops the scoreboard whenever a result handshake happens.
    initial begin
        forever begin
            @(negedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    chk("res_onehot", 32'($countones(res_valid)), 1);
                    if (exp_q[i].size() == 0) begin
                        total++; bad++;
                        $display("FAIL res_unexpected: got result %0h for requester %0d want none",
                                 res_data, i);
                    end else begin
                        chk($sformatf("res_data_r%0d", i), 32'(res_data), 32'(exp_q[i].pop_front()));
                    end
                    obs_order.push_back(i);
                    obs_cyc.push_back(cyc);
                    obs_vec.push_back(res_valid);
                end
            end
        end
    end

    function automatic int at(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -99;
    endfunction

    initial begin
        int exp3 [8];
`ifdef FP_ARB_FIXED_PRIO_EN
        exp3 = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        do_reset();

        // Single request from requester 2, latency 6.
        @(posedge clk);
        lat = 6;
        send(2, 16'h4000);
        wait_idle("single");
        chk("single_grants", 32'(grant_log.size()), 1);
        chk("single_grant_idx", 32'(at(grant_log, 0)), 2);
        chk("single_issue_lat", 32'(at(iss_cyc, 0) - at(grant_cyc, 0)), 1);
        chk("single_res_lat", 32'(at(obs_cyc, 0) - at(iss_cyc, 0)), 6);
        chk("single_res_vec", 32'(obs_vec.size() > 0 ? obs_vec[0] : 4'hF), 32'(4'b0100));

        // All four requesters, two ops each.
        do_reset();
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) send(i, 16'h4000 + 16'(i * 16 + k));
        wait_idle("all4");
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("all4_grant%0d", k), 32'(at(grant_log, k)), 32'(exp3[k]));
            chk($sformatf("all4_res%0d", k), 32'(at(obs_order, k)), 32'(exp3[k]));
        end
        chk("all4_back_to_back", 32'(at(grant_cyc, 7) - at(grant_cyc, 0)), 7);

        // Multiplier stall with requesters 1 and 3 pending.
        do_reset();
        @(posedge clk);
        tready_cfg = 1'b0;
        send(1, 16'h4400);
        send(3, 16'h4200);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #3;
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_tvalid", 32'({m_a_tvalid, m_b_tvalid}), 32'(2'b11));
            chk("stall_tdata", 32'({m_a_tdata, m_b_tdata}), 32'({16'h3C00, 16'h4400}));
        end
        @(posedge clk);
        tready_cfg = 1'b1;
        wait_idle("stall");
        chk("stall_grant0", 32'(at(grant_log, 0)), 1);
        chk("stall_grant1", 32'(at(grant_log, 1)), 3);

        // Latency 10, continuous requests: tag FIFO must cap outstanding at TAG_DEPTH.
        do_reset();
        @(posedge clk);
        lat = 10;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < N; i++) send(i, 16'h4800 + 16'(i * 256 + k));
        wait_idle("depth");
        chk("depth_max_outstanding", 32'(max_out), TD);
        chk("depth_results", 32'(obs_order.size()), 24);

        // Result backpressure on requester 1 at the FIFO head.
        do_reset();
        @(posedge clk);
        lat = 6;
        res_rdy_cfg = 4'b1101;
        send(1, 16'h4400);
        send(2, 16'h4500);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk); #3;
                n++;
            end while (!res_valid[1] && n < 50);
            chk("bp_head_seen", 32'(n < 50), 1);
        end
        for (int k = 0; k < 3; k++) begin
            chk("bp_m_res_tready", 32'(m_res_tready), 0);
            chk("bp_res_valid", 32'(res_valid), 32'(4'b0010));
            chk("bp_res_data", 32'(res_data), 32'(16'h4400));
            chk("bp_outstanding", 32'(out_cnt), 2);
            @(negedge clk); #3;
        end
        res_rdy_cfg = '1;
        wait_idle("bp");
        chk("bp_order0", 32'(at(obs_order, 0)), 1);
        chk("bp_order1", 32'(at(obs_order, 1)), 2);

        // Orphan result with nothing outstanding.
        do_reset();
        @(posedge clk);
        orphan_inj = 1'b1;
        @(negedge clk); #3;
        chk("orphan_res_valid", 32'(res_valid), 0);
        chk("orphan_m_res_tready", 32'(m_res_tready), 1);
        @(posedge clk);
        orphan_inj = 1'b0;
        @(negedge clk); #3;
        chk("orphan_err_set", 32'(err_orphan), 1);
        repeat (2) @(negedge clk);
        #3;
        chk("orphan_err_sticky", 32'(err_orphan), 1);
        rst_n = 1'b0;
        #1;
        chk("orphan_err_cleared", 32'(err_orphan), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
